// File: rtl/pdm_cic_decimator.sv
// CIC decimator: 1-bit PDM stream in, signed OUT_WIDTH PCM samples out at pdm rate / DECIM.
// Integrators run on each PDM tick; the comb chain runs one stage per clk_in after a window closes.
module pdm_cic_decimator #(
  parameter int ORDER     = 3,
  parameter int DECIM     = 64,
  parameter int OUT_WIDTH = 16
) (
  input  logic                        clk_in,
  input  logic                        rst_in,
  input  logic                        pdm_tick_in,
  input  logic                        pdm_bit_in,
  output logic signed [OUT_WIDTH-1:0] sample_out,
  output logic                        sample_valid_out,
  output logic                        clipped_out
);
  localparam int PW  = $clog2(DECIM);
  localparam int G   = ORDER * PW;
  localparam int W   = G + 2;
  localparam int SH  = G - (OUT_WIDTH - 1);
  localparam int WCW = $clog2(ORDER + 1);
  localparam logic signed [W-1:0]         POS_FS = W'(1) << (OUT_WIDTH - 1);
  localparam logic signed [OUT_WIDTH-1:0] MAX_S  = {1'b0, {(OUT_WIDTH-1){1'b1}}};

  if (G < OUT_WIDTH - 1 || (DECIM & (DECIM - 1)) != 0 || ORDER < 1 || ORDER > 5) begin : g_bad_cfg
    $error("pdm_cic_decimator: unsupported ORDER/DECIM/OUT_WIDTH combination");
  end

  logic [ORDER-1:0][W-1:0] integ, stage_in;
  logic [ORDER-1:0][W-1:0] comb_y, comb_prev, comb_in;
  logic [PW-1:0]           phase;
  logic [WCW-1:0]          warm_cnt;
  logic                    emit;
  logic [ORDER:0]          vld_pipe;
  logic [W-1:0]            x_in;
  logic signed [W-1:0]     scaled;
  logic                    win_close, sat;

  // bit 1 -> +1, bit 0 -> -1 (all ones)
  assign x_in      = {{(W-1){~pdm_bit_in}}, 1'b1};
  assign win_close = pdm_tick_in && (phase == PW'(DECIM - 1));
  assign scaled    = $signed(comb_y[ORDER-1]) >>> SH;
  assign sat       = (scaled == POS_FS);

  always_comb begin
    stage_in    = '0;
    comb_in     = '0;
    stage_in[0] = x_in;
    comb_in[0]  = integ[ORDER-1];
    for (int k = 1; k < ORDER; k++) begin
      stage_in[k] = integ[k-1];
      comb_in[k]  = comb_y[k-1];
    end
  end

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      integ            <= '0;
      comb_y           <= '0;
      comb_prev        <= '0;
      phase            <= '0;
      warm_cnt         <= '0;
      emit             <= 1'b0;
      vld_pipe         <= '0;
      sample_out       <= '0;
      sample_valid_out <= 1'b0;
      clipped_out      <= 1'b0;
    end else begin
      vld_pipe         <= {vld_pipe[ORDER-1:0], win_close};
      sample_valid_out <= vld_pipe[ORDER] & emit;
      // integrators wrap mod 2^W on purpose; the combs cancel the wrap
      if (pdm_tick_in) begin
        phase <= phase + PW'(1);
        for (int k = 0; k < ORDER; k++) integ[k] <= integ[k] + stage_in[k];
      end
      if (win_close) begin
        emit <= (warm_cnt == WCW'(ORDER));
        if (warm_cnt != WCW'(ORDER)) warm_cnt <= warm_cnt + WCW'(1);
      end
      for (int k = 0; k < ORDER; k++) begin
        if (vld_pipe[k]) begin
          comb_y[k]    <= comb_in[k] - comb_prev[k];
          comb_prev[k] <= comb_in[k];
        end
      end
      if (vld_pipe[ORDER] && emit) begin
        sample_out  <= sat ? MAX_S : scaled[OUT_WIDTH-1:0];
        clipped_out <= sat;
      end
    end
  end
endmodule
